// File: rtl/resp_tx_formatter.sv
// Formats an ALU result as an ASCII response line ("=<hex>\r\n" or "=ERR\r\n")
// and feeds it byte by byte to a UART transmitter using a start/busy handshake.
module resp_tx_formatter #(
    parameter bit LZ_SUPPRESS = 1'b1,
    parameter int RES_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [RES_W-1:0] result,
    input  logic             err,
    input  logic             tx_busy,
    output logic [7:0]       tx_data,
    output logic             tx_start,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_HOLD,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [7:0] CH_EQ = 8'h3D;
    localparam logic [7:0] CH_E  = 8'h45;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [RES_W-1:0] res_q, res_d;
    logic             err_q, err_d;
    logic [7:0]       tx_data_d;
    logic             tx_start_d, busy_d, done_d;

    logic [1:0] first_nib;
    logic [1:0] nib_pos;
    logic [3:0] nib;
    logic [2:0] last_idx;
    logic [7:0] cur_char;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Most significant nibble that gets printed; nibble 0 is always printed.
    always_comb begin
        first_nib = 2'd3;
        if (LZ_SUPPRESS) begin
            first_nib = 2'd0;
            for (int i = 1; i < 4; i++) begin
                if (res_q[4*i +: 4] != 4'h0) first_nib = 2'(i);
            end
        end
    end

    assign last_idx = err_q ? 3'd5 : ({1'b0, first_nib} + 3'd3);

    // Character at position idx_q of the response line.
    always_comb begin
        nib_pos  = 2'(({1'b0, first_nib} + 3'd1) - idx_q);
        nib      = res_q[{nib_pos, 2'b00} +: 4];
        cur_char = CH_LF;
        if (idx_q == 3'd0) begin
            cur_char = CH_EQ;
        end else if (err_q) begin
            case (idx_q)
                3'd1:       cur_char = CH_E;
                3'd2, 3'd3: cur_char = CH_R;
                3'd4:       cur_char = CH_CR;
                default:    cur_char = CH_LF;
            endcase
        end else if (idx_q <= ({1'b0, first_nib} + 3'd1)) begin
            cur_char = hex_char(nib);
        end else if (idx_q == ({1'b0, first_nib} + 3'd2)) begin
            cur_char = CH_CR;
        end
    end

    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        res_d      = res_q;
        err_d      = err_q;
        tx_data_d  = tx_data;
        tx_start_d = 1'b0;
        busy_d     = busy;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // done is still high in the cycle after S_DONE; a start there is dropped.
                if (start && !done) begin
                    res_d   = result;
                    err_d   = err;
                    idx_d   = 3'd0;
                    busy_d  = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_data_d  = cur_char;
                    tx_start_d = 1'b1;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: state_d = S_WAIT;
            S_WAIT: begin
                if (!tx_busy) begin
                    if (idx_q == last_idx) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_SEND;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            res_q    <= res_d;
            err_q    <= err_d;
            tx_data  <= tx_data_d;
            tx_start <= tx_start_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_resp_tx_formatter.sv
// Directed bench: two formatter instances (leading-zero suppression on and off)
// driven by shared stimulus; instance a sits behind a UART TX model.
module tb_resp_tx_formatter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] result;
    logic        err;
    logic        tx_busy_a;
    logic        tx_busy_b;
    logic [7:0]  tx_data_a, tx_data_b;
    logic        tx_start_a, tx_start_b;
    logic        busy_a, busy_b;
    logic        done_a, done_b;

    int total = 0;
    int bad   = 0;

    int          cyc = 0;
    int          busy_len = 0;
    int          tx_cnt = 0;
    logic [63:0] pk_a, pk_b;
    int          n_a, n_b;
    int          done_cnt_a, done_cnt_b, done_cyc_a;
    int          first_tx_a, last_tx_a, busy_cyc_a, viol_a;
    logic [7:0]  prev_data_a = 8'h00;

    resp_tx_formatter #(.LZ_SUPPRESS(1'b1), .RES_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start), .result(result), .err(err),
        .tx_busy(tx_busy_a), .tx_data(tx_data_a), .tx_start(tx_start_a),
        .busy(busy_a), .done(done_a)
    );

    resp_tx_formatter #(.LZ_SUPPRESS(1'b0), .RES_W(16)) dut_b (
        .clk(clk), .rst(rst), .start(start), .result(result), .err(err),
        .tx_busy(tx_busy_b), .tx_data(tx_data_b), .tx_start(tx_start_b),
        .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        pk_a = '0; pk_b = '0; n_a = 0; n_b = 0;
        done_cnt_a = 0; done_cnt_b = 0; done_cyc_a = -1;
        first_tx_a = -1; last_tx_a = -100; busy_cyc_a = 0; viol_a = 0;
    endtask

    // Monitor and TX model, evaluated away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            prev_data_a = tx_data_a;
        end else begin
            if (tx_start_a) begin
                if (tx_busy_a) viol_a++;
                if (cyc - last_tx_a < 3) viol_a++;
                if (first_tx_a < 0) first_tx_a = cyc;
                last_tx_a = cyc;
                pk_a = {pk_a[55:0], tx_data_a};
                n_a++;
            end else if (tx_data_a != prev_data_a) begin
                viol_a++;
            end
            prev_data_a = tx_data_a;
            if (tx_start_b) begin
                pk_b = {pk_b[55:0], tx_data_b};
                n_b++;
            end
            if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
            if (done_b) done_cnt_b++;
            if (busy_a) busy_cyc_a++;
        end
        if (tx_start_a) tx_cnt = busy_len;
        else if (tx_cnt > 0) tx_cnt--;
        tx_busy_a = (tx_cnt != 0);
    end

    // Pulses start once, then re-pulses it (with other data) at offsets x1/x2 (0 = none).
    task automatic run_job(input logic [15:0] res, input logic e, input int x1, input int x2,
                           output int s_cyc);
        int n;
        clear_mon();
        @(negedge clk);
        start = 1'b1; result = res; err = e; s_cyc = cyc;
        n = 0;
        do begin
            @(negedge clk);
            start  = (x1 != 0 && cyc == s_cyc + x1) || (x2 != 0 && cyc == s_cyc + x2);
            result = 16'h0BAD;
            err    = 1'b0;
            n++;
        end while (!(done_cnt_a > 0 && done_cnt_b > 0) && n < 2000);
        start = 1'b0;
        check("job_finished", {63'd0, done_cnt_a > 0 && done_cnt_b > 0}, 64'd1);
        repeat (30) @(negedge clk);
    endtask

    initial begin
        int s;
        int n;
        tx_busy_b = 1'b0;
        tx_busy_a = 1'b0;
        clear_mon();

        // Reset held while start is asserted.
        rst = 1'b0; start = 1'b1; result = 16'h00A5; err = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1; start = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_no_tx", 64'(n_a + n_b), 64'd0);
        check("rst_busy", {62'd0, busy_a, busy_b}, 64'd0);
        check("rst_data", {48'd0, tx_data_a, tx_data_b}, 64'd0);
        check("rst_done", 64'(done_cnt_a + done_cnt_b), 64'd0);

        // 00A5, ideal TX: latency and busy window.
        run_job(16'h00A5, 1'b0, 0, 0, s);
        check("a5_lz_bytes", pk_a, 64'h3D41350D0A);
        check("a5_lz_len", 64'(n_a), 64'd5);
        check("a5_full_bytes", pk_b, 64'h3D303041350D0A);
        check("a5_first_tx", 64'(first_tx_a - s), 64'd2);
        check("a5_done_lat", 64'(done_cyc_a - last_tx_a), 64'd3);
        check("a5_busy_cyc", 64'(busy_cyc_a), 64'd16);
        check("a5_done_cnt", 64'(done_cnt_a), 64'd1);

        // Zero result.
        run_job(16'h0000, 1'b0, 0, 0, s);
        check("zero_lz_bytes", pk_a, 64'h3D300D0A);
        check("zero_full_bytes", pk_b, 64'h3D303030300D0A);

        // Error response ignores result digits.
        run_job(16'h1234, 1'b1, 0, 0, s);
        check("err_bytes_a", pk_a, 64'h3D4552520D0A);
        check("err_bytes_b", pk_b, 64'h3D4552520D0A);

        // Slow TX: busy for 10 cycles after every tx_start.
        busy_len = 10;
        run_job(16'hFFFF, 1'b0, 0, 0, s);
        check("slow_bytes_a", pk_a, 64'h3D464646460D0A);
        check("slow_bytes_b", pk_b, 64'h3D464646460D0A);
        check("slow_handshake", 64'(viol_a), 64'd0);
        busy_len = 0;

        // Extra starts mid-string and in the done cycle of instance a.
        run_job(16'h00A5, 1'b0, 7, 17, s);
        check("extra_bytes_a", pk_a, 64'h3D41350D0A);
        check("extra_len_a", 64'(n_a), 64'd5);
        check("extra_done_cnt", 64'(done_cnt_a), 64'd1);
        check("extra_done_cyc", 64'(done_cyc_a - s), 64'd17);
        check("extra_bytes_b", pk_b, 64'h3D303041350D0A);
        check("extra_handshake", 64'(viol_a), 64'd0);

        // Reset after the second byte.
        clear_mon();
        @(negedge clk);
        start = 1'b1; result = 16'h1234; err = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (n_a < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_two_bytes", pk_a, 64'h3D31);
        rst = 1'b0;
        #1;
        check("mid_rst_outs", {61'd0, tx_start_a, busy_a, done_a}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        check("mid_idle_after", 64'(n_a), 64'd2);
        check("mid_idle_busy", {63'd0, busy_a}, 64'd0);
        run_job(16'h0007, 1'b0, 0, 0, s);
        check("post_rst_a", pk_a, 64'h3D370D0A);
        check("post_rst_b", pk_b, 64'h3D303030370D0A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
